// File: rtl/char_pixel_serializer.sv
// Character-cell pixel serializer: turns glyph rows from the character ROM
// into a registered RGB stream, tracking text column, text line and glyph row.
module char_pixel_serializer #(
  parameter logic [2:0] FG_COLOR = 3'b111,
  parameter logic [2:0] BG_COLOR = 3'b000,
  parameter int         COLS     = 80,
  parameter int         ROWS     = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_tick,
  input  logic       line_start,
  input  logic       frame_start,
  input  logic       video_on,
  input  logic [7:0] font_data,
  output logic [3:0] font_row,
  output logic [6:0] char_col,
  output logic [4:0] char_line,
  output logic [2:0] rgb,
  output logic       pixel_valid
);

  typedef enum logic {
    IDLE   = 1'b0,
    SYNCED = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] fr_q, fr_d;
  logic [6:0] cc_q, cc_d;
  logic [4:0] cl_q, cl_d;
  logic [2:0] bc_q, bc_d;
  logic [7:0] sh_q, sh_d;
  logic       fl_q, fl_d;
  logic [2:0] rgb_q, rgb_d;
  logic       pv_q, pv_d;

  logic synced;
  logic restart;
  logic load;
  logic pbit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (frame_start) state_d = SYNCED;
      SYNCED:  state_d = SYNCED;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fr_d    = fr_q;
    cc_d    = cc_q;
    cl_d    = cl_q;
    bc_d    = bc_q;
    sh_d    = sh_q;
    fl_d    = fl_q;
    rgb_d   = rgb_q;
    pv_d    = 1'b0;
    load    = 1'b0;
    pbit    = 1'b0;
    synced  = (state_q == SYNCED);
    restart = frame_start | (line_start & synced);

    // frame/line strobes own the counters over a coincident pixel tick
    if (frame_start) begin
      fr_d = '0;
      cl_d = '0;
      cc_d = '0;
      bc_d = '0;
      fl_d = ~line_start;
    end else if (line_start && synced) begin
      cc_d = '0;
      bc_d = '0;
      if (fl_q) begin
        fl_d = 1'b0;
      end else begin
        fr_d = fr_q + 4'd1;
        if (fr_q == 4'd15) begin
          cl_d = (cl_q == 5'(ROWS - 1)) ? 5'd0 : cl_q + 5'd1;
        end
      end
    end

    if (synced && pix_tick) begin
      pv_d = 1'b1;
      if (video_on) begin
        load  = restart | (bc_q == 3'd0);
        pbit  = load ? font_data[7] : sh_q[7];
        sh_d  = load ? {font_data[6:0], 1'b0}
                     : {sh_q[6:0], 1'b0};
        rgb_d = pbit ? FG_COLOR : BG_COLOR;
        if (!restart) begin
          bc_d = bc_q + 3'd1;
          if (bc_q == 3'd7) begin
            cc_d = (cc_q == 7'(COLS - 1)) ? 7'd0
                                          : cc_q + 7'd1;
          end
        end
      end else begin
        rgb_d = 3'b000;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fr_q  <= '0;
      cc_q  <= '0;
      cl_q  <= '0;
      bc_q  <= '0;
      sh_q  <= '0;
      fl_q  <= 1'b0;
      rgb_q <= '0;
      pv_q  <= 1'b0;
    end else begin
      fr_q  <= fr_d;
      cc_q  <= cc_d;
      cl_q  <= cl_d;
      bc_q  <= bc_d;
      sh_q  <= sh_d;
      fl_q  <= fl_d;
      rgb_q <= rgb_d;
      pv_q  <= pv_d;
    end
  end

  assign font_row    = fr_q;
  assign char_col    = cc_q;
  assign char_line   = cl_q;
  assign rgb         = rgb_q;
  assign pixel_valid = pv_q;

endmodule

// File: tb/tb_char_pixel_serializer.sv
// Bench for char_pixel_serializer: directed steps plus random traffic
// compared against a line/pixel-count reference model.
module tb_char_pixel_serializer;

  localparam logic [2:0] FG   = 3'b111;
  localparam logic [2:0] BG   = 3'b000;
  localparam int         COLS = 80;
  localparam int         ROWS = 30;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pix_tick;
  logic       line_start;
  logic       frame_start;
  logic       video_on;
  logic [7:0] font_data;
  logic [3:0] font_row;
  logic [6:0] char_col;
  logic [4:0] char_line;
  logic [2:0] rgb;
  logic       pixel_valid;

  int passed = 0;
  int total  = 0;

  // reference model: line count since frame start, active pixels in line
  bit         m_sync;
  int         m_line;
  int         m_pix;
  logic [7:0] m_glyph;
  logic [2:0] m_rgb;
  logic       m_pv;

  char_pixel_serializer #(
    .FG_COLOR(FG),
    .BG_COLOR(BG),
    .COLS    (COLS),
    .ROWS    (ROWS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_tick   (pix_tick),
    .line_start (line_start),
    .frame_start(frame_start),
    .video_on   (video_on),
    .font_data  (font_data),
    .font_row   (font_row),
    .char_col   (char_col),
    .char_line  (char_line),
    .rgb        (rgb),
    .pixel_valid(pixel_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d want %0d", tag, obs, exp);
  endtask

  function automatic int lines_done();
    return (m_line < 0) ? 0 : m_line;
  endfunction

  task automatic model_reset();
    m_sync  = 1'b0;
    m_line  = -1;
    m_pix   = 0;
    m_glyph = '0;
    m_rgb   = '0;
    m_pv    = 1'b0;
  endtask

  task automatic model(bit fs, bit ls, bit pt, bit vo,
                       logic [7:0] fd);
    bit was;
    bit rs;
    int pos;
    was = m_sync;
    rs  = fs || (ls && was);
    if (fs) begin
      m_sync = 1'b1;
      m_line = ls ? 0 : -1;
      m_pix  = 0;
    end else if (ls && was) begin
      m_line++;
      m_pix = 0;
    end
    if (was && pt) begin
      m_pv = 1'b1;
      if (vo) begin
        pos = rs ? 0 : m_pix % 8;
        if (pos == 0) m_glyph = fd;
        m_rgb = m_glyph[7-pos] ? FG : BG;
        if (!rs) m_pix++;
      end else begin
        m_rgb = 3'b000;
      end
    end else begin
      m_pv = 1'b0;
    end
  endtask

  task automatic check_all();
    chk("rgb", 32'(rgb), 32'(m_rgb));
    chk("pixel_valid", 32'(pixel_valid), 32'(m_pv));
    chk("font_row", 32'(font_row), 32'(lines_done() % 16));
    chk("char_col", 32'(char_col), 32'((m_pix / 8) % COLS));
    chk("char_line", 32'(char_line),
        32'((lines_done() / 16) % ROWS));
  endtask

  task automatic step(bit fs, bit ls, bit pt, bit vo,
                      logic [7:0] fd);
    @(negedge clk);
    frame_start = fs;
    line_start  = ls;
    pix_tick    = pt;
    video_on    = vo;
    font_data   = fd;
    @(posedge clk);
    model(fs, ls, pt, vo, fd);
    #1;
    check_all();
  endtask

  initial begin
    logic [2:0] seq [8];
    seq = '{BG, FG, FG, BG, FG, FG, BG, BG};
    rst_n       = 1'b0;
    pix_tick    = 1'b0;
    line_start  = 1'b0;
    frame_start = 1'b0;
    video_on    = 1'b0;
    font_data   = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all();
    @(negedge clk) rst_n = 1'b1;

    // no frame_start yet: ticks and lines must be ignored
    for (int i = 0; i < 12; i++)
      step(1'b0, i % 5 == 0, 1'b1, 1'b1, 8'hff);

    // one glyph row, bit 7 first
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 8'b01101100);
      chk("seq_rgb", 32'(rgb), 32'(seq[i]));
      chk("seq_valid", 32'(pixel_valid), 32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      chk("seq_gap", 32'(pixel_valid), 32'd0);
    end
    chk("seq_col", 32'(char_col), 32'd1);

    // blanked tick mid-cell holds bit position
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 1'b1, 1'b1, 8'hb5);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("blank_rgb", 32'(rgb), 32'd0);
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    chk("blank_col", 32'(char_col), 32'd2);

    // glyph row sweep over 17 lines
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 17; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      chk("fr_seq", 32'(font_row), 32'(i % 16));
    end
    chk("line_wrap", 32'(char_line), 32'd1);

    // full line wraps the column counter
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < COLS * 8; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 8'($urandom));
      if (i == COLS * 8 - 2)
        chk("col_last", 32'(char_col), 32'(COLS - 1));
    end
    chk("col_wrap", 32'(char_col), 32'd0);

    // coincident frame and line start
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("co_fr0", 32'(font_row), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("co_fr1", 32'(font_row), 32'd1);

    // random traffic
    for (int i = 0; i < 600; i++)
      step(1'b0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 7) != 0, 8'($urandom));

    // asynchronous reset mid-cell
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 1'b1, 1'b1, 8'hff);
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'hff);
    @(negedge clk);
    pix_tick = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_rgb", 32'(rgb), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 6; i++)
      step(1'b0, i == 2, 1'b1, 1'b1, 8'hff);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b0, 1'b1, 1'b1, 8'h81);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/char_pixel_serializer.md
CHAR_PIXEL_SERIALIZER -- requirements
Module: char_pixel_serializer

Interface
REQ-001 SHALL have parameter FG_COLOR, default 3'b111, RGB driven for a set glyph bit.
REQ-002 SHALL have parameter BG_COLOR, default 3'b000, RGB driven for a clear glyph bit inside the active video region.
REQ-003 SHALL have parameter COLS, default 80, number of character columns per line.
REQ-004 SHALL have parameter ROWS, default 30, number of character lines per frame.
REQ-005 SHALL have port clk  input  1  single system clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port pix_tick  input  1  one-cycle strobe, one per VGA pixel.
REQ-008 SHALL have port line_start  input  1  one-cycle strobe at the start of each visible scan line.
REQ-009 SHALL have port frame_start  input  1  one-cycle strobe at the start of each frame.
REQ-010 SHALL have port video_on  input  1  high while the current pixel is in the visible area.
REQ-011 SHALL have port font_data  input  8  glyph row bits from the character ROM; bit 7 is the leftmost pixel.
REQ-012 SHALL have port font_row  output  4  glyph row address to the character ROM.
REQ-013 SHALL have port char_col  output  7  current character column, 0..COLS-1.
REQ-014 SHALL have port char_line  output  5  current character line, 0..ROWS-1.
REQ-015 SHALL have port rgb  output  3  registered pixel colour.
REQ-016 SHALL have port pixel_valid  output  1  high for one cycle when rgb carries a new pixel.

Function
REQ-017 SHALL implement two states: IDLE (after reset) and SYNCED; IDLE->SYNCED on frame_start; no other transition except reset.
REQ-018 SHALL, in IDLE, hold rgb=0 and pixel_valid=0 and ignore pix_tick and line_start.
REQ-019 SHALL, on frame_start, set font_row=0, char_line=0, char_col=0, bit_cnt=0, and set first_line=1.
REQ-020 SHALL, on line_start in SYNCED with first_line=1, clear first_line and leave font_row unchanged.
REQ-021 SHALL, on line_start in SYNCED with first_line=0, increment font_row modulo 16.
REQ-022 SHALL, when font_row wraps 15->0 in REQ-021, increment char_line, wrapping ROWS-1->0.
REQ-023 SHALL, on every line_start in SYNCED, set char_col=0 and bit_cnt=0.
REQ-024 SHALL treat frame_start and line_start in the same cycle as frame_start followed by the first line: font_row=0, first_line=0.
REQ-025 SHALL, on pix_tick with video_on=1 and bit_cnt=0, load shreg<=font_data<<1 and select font_data[7] as the pixel bit.
REQ-026 SHALL, on pix_tick with video_on=1 and bit_cnt!=0, select shreg[7] and shift shreg left by 1.
REQ-027 SHALL, on each such video_on=1 pix_tick, register rgb=FG_COLOR for pixel bit 1 and BG_COLOR for 0, and assert pixel_valid the next cycle (latency 1 clk from pix_tick).
REQ-028 SHALL increment bit_cnt modulo 8 on each video_on=1 pix_tick; on 7->0, char_col SHALL increment, wrapping COLS-1->0.
REQ-029 SHALL, on pix_tick with video_on=0, register rgb=3'b000 with pixel_valid=1 and leave bit_cnt, shreg and char_col unchanged.
REQ-030 SHALL drive pixel_valid=0 and hold rgb in every cycle without pix_tick.
REQ-031 SHALL give line_start or frame_start priority over a coincident pix_tick for counters; the pixel of that cycle SHALL use bit_cnt=0 with a fresh font_data load.
REQ-032 SHALL drive font_row combinationally from its register so that font_data is stable one full cycle before the next load.

Reset
REQ-033 SHALL, while rst_n=0 regardless of clk, force state=IDLE, font_row=0, char_col=0, char_line=0, bit_cnt=0, shreg=0, first_line=0, rgb=0 and pixel_valid=0.
REQ-034 SHALL, on reset assertion mid-line, abort serialization immediately and require a new frame_start to leave IDLE.

Verification
REQ-035 SHALL verify: reset release then pix_tick with no frame_start -> rgb=0 and pixel_valid=0 throughout.
REQ-036 SHALL verify: frame_start, line_start, then 8 pix_ticks with video_on=1 and font_data=8'b01101100 -> rgb sequence BG,FG,FG,BG,FG,FG,BG,BG, each valid 1 clk after its tick, then char_col=1.
REQ-037 SHALL verify: 17 line_starts after frame_start -> font_row sequence 0,1..15,0, and char_line=1 after the wrap.
REQ-038 SHALL verify: COLS*8 active pix_ticks on one line -> char_col wraps 79->0; a video_on=0 tick mid-cell -> rgb=0 and bit_cnt held.
REQ-039 SHALL verify: frame_start coincident with line_start -> font_row=0, and the next line_start gives font_row=1.
REQ-040 SHALL verify: rst_n pulsed low mid-cell -> all outputs 0 within the same cycle without a clk edge, and state=IDLE until the next frame_start.
